mmio_timer_slave: RTL and testbench

//  Memory-mapped machine-timer responder on the core's data-memory port (MemWriteM/ALUResultM/WriteDataM/funct3M -> ReadData).

---
 rtl/riscv_mem_pkg.sv | 26 ++
 rtl/mmio_lane_unit.sv | 71 +++++++
 rtl/mmio_timer_slave.sv | 140 ++++++++++++++
 tb/tb_mmio_timer_slave.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory port: load/store size codes, timer register offsets, CTRL fields.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_mem_pkg;

    // funct3 access size / signedness codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Timer register byte offsets inside the 64-byte window (word aligned)
    localparam logic [5:0] TMR_MTIME_LO    = 6'h00;
    localparam logic [5:0] TMR_MTIME_HI    = 6'h04;
    localparam logic [5:0] TMR_MTIMECMP_LO = 6'h08;
    localparam logic [5:0] TMR_MTIMECMP_HI = 6'h0C;
    localparam logic [5:0] TMR_CTRL        = 6'h10;
    localparam logic [5:0] TMR_STATUS      = 6'h14;

    // CTRL register bit positions
    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_PRESC_LSB = 8;

endpackage

// File: rtl/mmio_lane_unit.sv
// Byte-lane helper: store byte-enable/merge into an existing word, and load lane extract with sign/zero extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; illegal sizes/alignments report o_store_ok=0 and load 0.
module mmio_lane_unit
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic        o_store_ok,
    output logic [31:0] o_merged,
    output logic [31:0] o_rdata
);

    logic [3:0]  w_be;
    logic [31:0] w_repl;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rword >> {i_addr_lo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    // Store path: decide legal access, lane enables and replicated data, then merge into the old word
    always_comb begin
        o_store_ok = 1'b0;
        w_be       = 4'b0000;
        w_repl     = i_wdata;
        o_merged   = i_rword;
        case (i_funct3)
            F3_B: begin
                o_store_ok = 1'b1;
                w_be       = 4'b0001 << i_addr_lo;
                w_repl     = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                if (!i_addr_lo[0]) begin
                    o_store_ok = 1'b1;
                    w_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    w_repl     = {2{i_wdata[15:0]}};
                end
            end
            F3_W: begin
                if (i_addr_lo == 2'b00) begin
                    o_store_ok = 1'b1;
                    w_be       = 4'b1111;
                end
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) o_merged[8*i +: 8] = w_repl[8*i +: 8];
        end
    end

    // Load path: extract the addressed lane and extend; misaligned or reserved codes return 0
    always_comb begin
        o_rdata = 32'h0;
        case (i_funct3)
            F3_B:  o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU: o_rdata = {24'h0, w_byte};
            F3_H:  if (!i_addr_lo[0]) o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU: if (!i_addr_lo[0]) o_rdata = {16'h0, w_half};
            F3_W:  if (i_addr_lo == 2'b00) o_rdata = i_rword;
            default: ;
        endcase
    end

endmodule

// File: rtl/mmio_timer_slave.sv
// Machine-timer responder on the data-memory port: 64-bit mtime/mtimecmp, prescaler, sticky pending irq.
// Latency: loads zero-cycle combinational; stores take effect at the clock edge they are presented.
// Backpressure: none; always ready, illegal accesses are silently dropped or read as 0.
module mmio_timer_slave
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        hit,
    output logic [31:0] ReadData,
    output logic        timer_irq
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = 1;

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic               r_en;
    logic               r_irq_en;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_pending;

    logic [5:0]  w_off;
    logic [31:0] w_rword;
    logic [31:0] w_merged;
    logic [31:0] w_rdata;
    logic        w_store_ok;
    logic        w_wr;
    logic        w_tick;
    logic        w_match;
    logic        w_clr;

    assign hit       = (ALUResultM[31:6] == BASE_ADDR[31:6]);
    assign w_off     = {ALUResultM[5:2], 2'b00};
    assign w_wr      = MemWriteM & hit & w_store_ok;
    assign w_tick    = r_en && (r_presc_cnt == r_presc);
    assign w_match   = (r_mtime >= r_mtimecmp);
    // Only byte/word stores that land on lane 0 of STATUS can carry the clear bit
    assign w_clr     = w_wr && (w_off == TMR_STATUS) && (ALUResultM[1:0] == 2'b00)
                       && ((funct3M == F3_B) || (funct3M == F3_W)) && WriteDataM[0];
    assign ReadData  = hit ? w_rdata : 32'h0;
    // Built only from registers so the irq line never follows the address bus
    assign timer_irq = r_pending & r_irq_en;

    // Select the addressed register word; unmapped offsets read 0
    always_comb begin
        w_rword = 32'h0;
        case (w_off)
            TMR_MTIME_LO:    w_rword = r_mtime[31:0];
            TMR_MTIME_HI:    w_rword = r_mtime[63:32];
            TMR_MTIMECMP_LO: w_rword = r_mtimecmp[31:0];
            TMR_MTIMECMP_HI: w_rword = r_mtimecmp[63:32];
            TMR_CTRL: begin
                w_rword[CTRL_EN]                         = r_en;
                w_rword[CTRL_IRQ_EN]                     = r_irq_en;
                w_rword[CTRL_PRESC_LSB +: PRESC_W]       = r_presc;
            end
            TMR_STATUS:      w_rword[0] = r_pending;
            default: ;
        endcase
    end

    mmio_lane_unit u_lane (
        .i_addr_lo  (ALUResultM[1:0]),
        .i_funct3   (funct3M),
        .i_wdata    (WriteDataM),
        .i_rword    (w_rword),
        .o_store_ok (w_store_ok),
        .o_merged   (w_merged),
        .o_rdata    (w_rdata)
    );

    // mtime: a store to either half beats the tick and freezes the other half for that cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime <= 64'h0;
        end else if (w_wr && (w_off == TMR_MTIME_LO)) begin
            r_mtime[31:0] <= w_merged;
        end else if (w_wr && (w_off == TMR_MTIME_HI)) begin
            r_mtime[63:32] <= w_merged;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp: plain read/write register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (w_wr && (w_off == TMR_MTIMECMP_LO)) begin
            r_mtimecmp[31:0] <= w_merged;
        end else if (w_wr && (w_off == TMR_MTIMECMP_HI)) begin
            r_mtimecmp[63:32] <= w_merged;
        end
    end

    // CTRL fields, updated from the lane-merged word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_presc  <= '0;
        end else if (w_wr && (w_off == TMR_CTRL)) begin
            r_en     <= w_merged[CTRL_EN];
            r_irq_en <= w_merged[CTRL_IRQ_EN];
            r_presc  <= w_merged[CTRL_PRESC_LSB +: PRESC_W];
        end
    end

    // Prescaler counter: held at 0 when disabled, restarted by any CTRL write, wraps on tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (!r_en || (w_wr && (w_off == TMR_CTRL))) begin
            r_presc_cnt <= '0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
        end else begin
            r_presc_cnt <= r_presc_cnt + PRESC_ONE;
        end
    end

    // Sticky pending: set while enabled and matched, which overrides a software clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= (r_en & w_match) | (r_pending & ~w_clr);
        end
    end

endmodule

// File: tb/tb_mmio_timer_slave.sv
// Directed bench for the machine timer: reset, prescaler, compare/irq, wrap, byte lanes, store-vs-tick.
// Latency: loads sampled 1ns after drive; stores land on the next rising edge.
// Backpressure: none modelled; the slave is always ready.
module tb_mmio_timer_slave;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        hit;
    logic [31:0] ReadData;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_timer_slave #(.BASE_ADDR(B), .PRESC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .hit        (hit),
        .ReadData   (ReadData),
        .timer_irq  (timer_irq)
    );

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        @(negedge clk);
        ALUResultM = a;
        WriteDataM = d;
        funct3M    = f3;
        MemWriteM  = 1'b1;
        @(posedge clk);
        #1;
        MemWriteM  = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
        MemWriteM  = 1'b0;
        ALUResultM = a;
        funct3M    = f3;
        #1;
        d = ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ld(B + 32'h08, 3'b010, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_lo got %h exp FFFFFFFF", d); end
        ld(B + 32'h0C, 3'b010, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi got %h exp FFFFFFFF", d); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", timer_irq); end
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo got %h exp 0", d); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got %b exp 1", hit); end
        ld(B + 32'h10, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        st(B + 32'h10, 32'h0000_0301, 3'b010);
        repeat (40) @(posedge clk);
        #1;
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'd10) begin errors++; $display("FAIL presc_mtime got %0d exp 10", d); end
        ld(B + 32'h10, 3'b010, d);
        checks++; if (d !== 32'h0000_0301) begin errors++; $display("FAIL presc_ctrl got %h exp 00000301", d); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL presc_irq got %b exp 0", timer_irq); end
        st(B + 32'h10, 32'h0, 3'b010);
    endtask

    task automatic test_compare();
        logic [31:0] d;
        st(B + 32'h0C, 32'h0, 3'b010);
        st(B + 32'h08, 32'd5, 3'b010);
        st(B + 32'h04, 32'h0, 3'b010);
        st(B + 32'h00, 32'h0, 3'b010);
        st(B + 32'h10, 32'h0000_0003, 3'b010);
        repeat (5) @(posedge clk);
        #1;
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'd5) begin errors++; $display("FAIL cmp_mtime5 got %0d exp 5", d); end
        ld(B + 32'h14, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmp_pend_early got %h exp 0", d); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL cmp_irq_early got %b exp 0", timer_irq); end
        @(posedge clk);
        #1;
        ld(B + 32'h14, 3'b010, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL cmp_pend_set got %h exp 1", d); end
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL cmp_irq_set got %b exp 1", timer_irq); end
        st(B + 32'h14, 32'h1, 3'b010);
        ld(B + 32'h14, 3'b010, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL cmp_pend_sticky got %h exp 1", d); end
        st(B + 32'h08, 32'hFFFF_FFFF, 3'b010);
        st(B + 32'h14, 32'h1, 3'b010);
        ld(B + 32'h14, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cmp_pend_clr got %h exp 0", d); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL cmp_irq_clr got %b exp 0", timer_irq); end
        st(B + 32'h10, 32'h0, 3'b010);
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [31:0] h;
        st(B + 32'h00, 32'hFFFF_FFFE, 3'b010);
        st(B + 32'h04, 32'h0, 3'b010);
        st(B + 32'h10, 32'h1, 3'b010);
        repeat (2) @(posedge clk);
        #1;
        ld(B + 32'h00, 3'b010, d);
        ld(B + 32'h04, 3'b010, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap32_lo got %h exp 0", d); end
        checks++; if (h !== 32'h1) begin errors++; $display("FAIL wrap32_hi got %h exp 1", h); end
        st(B + 32'h10, 32'h0, 3'b010);
        st(B + 32'h00, 32'hFFFF_FFFF, 3'b010);
        st(B + 32'h04, 32'hFFFF_FFFF, 3'b010);
        ld(B + 32'h04, 3'b010, h);
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap64_pre_hi got %h exp FFFFFFFF", h); end
        st(B + 32'h10, 32'h1, 3'b010);
        @(posedge clk);
        #1;
        ld(B + 32'h00, 3'b010, d);
        ld(B + 32'h04, 3'b010, h);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL wrap64_lo got %h exp 0", d); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL wrap64_hi got %h exp 0", h); end
        st(B + 32'h10, 32'h0, 3'b010);
    endtask

    task automatic test_lanes();
        logic [31:0] d;
        st(B + 32'h08, 32'hFFFF_FFFF, 3'b010);
        st(B + 32'h09, 32'h0000_00A5, 3'b000);
        ld(B + 32'h08, 3'b010, d);
        checks++; if (d !== 32'hFFFF_A5FF) begin errors++; $display("FAIL sb_merge got %h exp FFFFA5FF", d); end
        ld(B + 32'h09, 3'b000, d);
        checks++; if (d !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb got %h exp FFFFFFA5", d); end
        ld(B + 32'h09, 3'b100, d);
        checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL lbu got %h exp 000000A5", d); end
        st(B + 32'h09, 32'h0000_1234, 3'b001);
        ld(B + 32'h08, 3'b010, d);
        checks++; if (d !== 32'hFFFF_A5FF) begin errors++; $display("FAIL sh_misaligned got %h exp FFFFA5FF", d); end
        ld(B + 32'h02, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL lw_misaligned got %h exp 0", d); end
        st(B + 32'h0A, 32'h0000_1234, 3'b001);
        ld(B + 32'h08, 3'b010, d);
        checks++; if (d !== 32'h1234_A5FF) begin errors++; $display("FAIL sh_hi got %h exp 1234A5FF", d); end
        ld(B + 32'h08, 3'b001, d);
        checks++; if (d !== 32'hFFFF_A5FF) begin errors++; $display("FAIL lh got %h exp FFFFA5FF", d); end
        ld(B + 32'h08, 3'b101, d);
        checks++; if (d !== 32'h0000_A5FF) begin errors++; $display("FAIL lhu got %h exp 0000A5FF", d); end
        ld(B + 32'h08, 3'b011, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL load_f3_011 got %h exp 0", d); end
        st(B + 32'h18, 32'h0000_DEAD, 3'b010);
        ld(B + 32'h18, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", d); end
        st(B + 32'h11, 32'hFFFF_FFFF, 3'b010);
        ld(B + 32'h10, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_misaligned_ctrl got %h exp 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        st(B + 32'h04, 32'h0, 3'b010);
        st(B + 32'h00, 32'h0, 3'b010);
        st(B + 32'h10, 32'h1, 3'b010);
        repeat (3) @(posedge clk);
        st(B + 32'h00, 32'h0000_0100, 3'b010);
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL store_wins got %h exp 00000100", d); end
        ld(B + 32'h04, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL store_hi_held got %h exp 0", d); end
        @(posedge clk);
        #1;
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL tick_after_store got %h exp 00000101", d); end
        ld(32'h2000_0000, 3'b010, d);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", hit); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL miss_data got %h exp 0", d); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d;
        st(B + 32'h10, 32'h0000_0303, 3'b010);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b0;
        ALUResultM = B + 32'h00;
        WriteDataM = 32'h0000_0055;
        funct3M    = 3'b010;
        MemWriteM  = 1'b1;
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        rst_n     = 1'b1;
        ld(B + 32'h00, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mtime got %h exp 0", d); end
        ld(B + 32'h10, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 0", d); end
        ld(B + 32'h0C, 3'b010, d);
        checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_mid_cmp_hi got %h exp FFFFFFFF", d); end
        ld(B + 32'h14, 3'b010, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_status got %h exp 0", d); end
    endtask

    initial begin
        rst_n      = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        funct3M    = 3'b010;
        test_reset();
        test_prescaler();
        test_compare();
        test_wrap();
        test_lanes();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
